// File: rtl/key_led_ctrl_param_if.sv
// Key/LED bundle between the board pins and the key_led_ctrl_param core.
// The master side drives keys and mode; the slave side drives the LEDs and press pulses.
interface key_led_ctrl_param_if #(
  parameter int unsigned KEY_NUM = 2
);
  logic [KEY_NUM-1:0] key;
  logic [1:0]         mode;
  logic [KEY_NUM-1:0] led;
  logic [KEY_NUM-1:0] key_press;

  modport master (output key, mode, input led, key_press);
  modport slave  (input key, mode, output led, key_press);
endinterface

// File: rtl/key_led_ctrl_param.sv
// Debounced KEY_NUM-key front end that drives KEY_NUM LEDs in momentary,
// toggle, blink or radio-select mode, and exports one pulse per accepted press.
module key_led_ctrl_param #(
  parameter int unsigned KEY_NUM      = 2,
  parameter int unsigned DEBOUNCE_CNT = 1_000_000,
  parameter int unsigned BLINK_CNT    = 25_000_000
) (
  input  logic                sys_clk,
  input  logic                rst,
  key_led_ctrl_param_if.slave bus
);
  localparam int unsigned   CW      = $clog2(DEBOUNCE_CNT);
  localparam int unsigned   BW      = $clog2(BLINK_CNT);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CNT - 1);
  localparam logic [BW-1:0] BL_LAST = BW'(BLINK_CNT - 1);

  typedef enum logic [1:0] {
    MOMENTARY = 2'b00,
    TOGGLE    = 2'b01,
    BLINK     = 2'b10,
    RADIO     = 2'b11
  } mode_t;

  logic [KEY_NUM-1:0] sync1, sync2, stable, stable_d1;
  logic [CW-1:0]      cnt [KEY_NUM];
  logic [BW-1:0]      blink_cnt, blink_cnt_next;
  logic               phase, phase_next;
  logic [KEY_NUM-1:0] st, st_next, led_next, press, lowest;
  logic [KEY_NUM-1:0] led_state, press_pulse;
  mode_t              cur_mode, mode_d;

  assign cur_mode      = mode_t'(bus.mode);
  assign press         = stable_d1 & ~stable;
  assign bus.led       = led_state;
  assign bus.key_press = press_pulse;

  always_comb begin
    blink_cnt_next = blink_cnt + 1'b1;
    phase_next     = phase;
    if (blink_cnt == BL_LAST) begin
      blink_cnt_next = '0;
      phase_next     = ~phase;
    end
  end

  // The press is acted on combinationally so the LED changes on the same edge as key_press.
  always_comb begin
    lowest = '0;
    for (int unsigned i = 0; i < KEY_NUM; i++)
      if (press[i] && (lowest == '0)) lowest[i] = 1'b1;

    st_next  = st;
    led_next = '0;
    if (cur_mode != mode_d) begin
      st_next = '0;
    end else begin
      case (cur_mode)
        MOMENTARY: led_next = ~stable;
        TOGGLE: begin
          st_next  = st ^ press;
          led_next = st_next;
        end
        BLINK: begin
          st_next  = st ^ press;
          led_next = st_next & {KEY_NUM{phase_next}};
        end
        RADIO: begin
          if (press != '0) st_next = lowest;
          led_next = st_next;
        end
      endcase
    end
  end

  // mode_d resets to MOMENTARY: any clear on the first edge hits an already-zero st.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      sync1       <= '1;
      sync2       <= '1;
      stable      <= '1;
      stable_d1   <= '1;
      for (int unsigned i = 0; i < KEY_NUM; i++) cnt[i] <= '0;
      blink_cnt   <= '0;
      phase       <= 1'b0;
      st          <= '0;
      mode_d      <= MOMENTARY;
      led_state   <= '0;
      press_pulse <= '0;
    end else begin
      sync1     <= bus.key;
      sync2     <= sync1;
      stable_d1 <= stable;
      for (int unsigned i = 0; i < KEY_NUM; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
      blink_cnt   <= blink_cnt_next;
      phase       <= phase_next;
      st          <= st_next;
      mode_d      <= cur_mode;
      led_state   <= led_next;
      press_pulse <= press;
    end
  end
endmodule

// File: tb/tb_key_led_ctrl_param.sv
// Bench for key_led_ctrl_param: a sample-level model queues expected outputs per edge,
// and each scenario task pops and compares them alongside direct timing checks.
module tb_key_led_ctrl_param;
  localparam int unsigned K  = 2;
  localparam int unsigned DB = 10;
  localparam int unsigned BL = 8;

  logic sys_clk = 1'b0;
  logic rst     = 1'b0;

  key_led_ctrl_param_if #(.KEY_NUM(K)) bus ();

  key_led_ctrl_param #(.KEY_NUM(K), .DEBOUNCE_CNT(DB), .BLINK_CNT(BL)) dut (
    .sys_clk(sys_clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [K-1:0] led;
    logic [K-1:0] kp;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned checks   = 0;
  int unsigned failures = 0;

  // Model: accepted level after DB equal raw samples, effect visible three edges later.
  logic [K-1:0] acc, dl0, dl1, dl2, lvl, prev_lvl, m_press, m_st, m_led;
  int unsigned  run [K];
  int unsigned  bcnt;
  logic         phase;
  logic [1:0]   m_mode_d;

  initial forever begin
    @(posedge sys_clk or negedge rst);
    if (!rst) begin
      exp_q.delete();
      acc = '1; dl0 = '1; dl1 = '1; dl2 = '1; prev_lvl = '1;
      m_st = '0; bcnt = 0; phase = 1'b0; m_mode_d = bus.mode;
      for (int i = 0; i < K; i++) run[i] = 0;
    end else begin
      for (int i = 0; i < K; i++) begin
        if (bus.key[i] !== acc[i]) begin
          run[i]++;
          if (run[i] == DB) begin
            acc[i] = bus.key[i];
            run[i] = 0;
          end
        end else begin
          run[i] = 0;
        end
      end
      lvl = dl2; dl2 = dl1; dl1 = dl0; dl0 = acc;
      m_press  = prev_lvl & ~lvl;
      prev_lvl = lvl;
      if (bcnt == BL - 1) begin
        bcnt  = 0;
        phase = ~phase;
      end else begin
        bcnt++;
      end
      m_led = '0;
      if (bus.mode != m_mode_d) begin
        m_st = '0;
      end else begin
        case (bus.mode)
          2'b00: m_led = ~lvl;
          2'b01: begin m_st = m_st ^ m_press; m_led = m_st; end
          2'b10: begin m_st = m_st ^ m_press; m_led = m_st & {K{phase}}; end
          default: begin
            if (m_press != '0) m_st = m_press & (~m_press + 1'b1);
            m_led = m_st;
          end
        endcase
      end
      m_mode_d = bus.mode;
      exp_q.push_back({m_led, m_press});
    end
  end

  task automatic test_reset();
    exp_t e;
    checks += 2;
    if (bus.led !== 2'b00) begin failures++; $display("FAIL reset_led got=%b want=00", bus.led); end
    if (bus.key_press !== 2'b00) begin failures++; $display("FAIL reset_press got=%b want=00", bus.key_press); end
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge sys_clk); #1;
      if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL reset_sb no expected entry"); end
      else begin
        e = exp_q.pop_front(); checks += 2;
        if (bus.led !== e.led) begin failures++; $display("FAIL reset_led c=%0d got=%b want=%b", c, bus.led, e.led); end
        if (bus.key_press !== e.kp) begin failures++; $display("FAIL reset_press c=%0d got=%b want=%b", c, bus.key_press, e.kp); end
      end
      @(negedge sys_clk);
    end
  endtask

  task automatic test_glitch();
    exp_t       e;
    logic [1:0] seen;
    for (int m = 0; m < 4; m++) begin
      bus.mode = m[1:0];
      seen = '0;
      for (int c = 0; c < 30; c++) begin
        bus.key = (c >= 4 && c < 12) ? 2'b10 : 2'b11;
        @(posedge sys_clk); #1;
        if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL glitch_sb no expected entry"); end
        else begin
          e = exp_q.pop_front(); checks += 2;
          if (bus.led !== e.led) begin failures++; $display("FAIL glitch_led m=%0d c=%0d got=%b want=%b", m, c, bus.led, e.led); end
          if (bus.key_press !== e.kp) begin failures++; $display("FAIL glitch_press m=%0d c=%0d got=%b want=%b", m, c, bus.key_press, e.kp); end
        end
        seen = seen | bus.led | bus.key_press;
        @(negedge sys_clk);
      end
      checks++;
      if (seen !== 2'b00) begin failures++; $display("FAIL glitch_quiet m=%0d got=%b want=00", m, seen); end
    end
  endtask

  task automatic test_toggle();
    exp_t e;
    int   pulse_q[$];
    bus.mode = 2'b01;
    for (int c = 0; c < 160; c++) begin
      bus.key = ((c % 80) >= 4 && (c % 80) < 54) ? 2'b10 : 2'b11;
      @(posedge sys_clk); #1;
      if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL toggle_sb no expected entry"); end
      else begin
        e = exp_q.pop_front(); checks += 2;
        if (bus.led !== e.led) begin failures++; $display("FAIL toggle_led c=%0d got=%b want=%b", c, bus.led, e.led); end
        if (bus.key_press !== e.kp) begin failures++; $display("FAIL toggle_press c=%0d got=%b want=%b", c, bus.key_press, e.kp); end
      end
      if (bus.key_press[0] === 1'b1) pulse_q.push_back(c);
      if (c == 79) begin
        checks++;
        if (bus.led !== 2'b01) begin failures++; $display("FAIL toggle_on got=%b want=01", bus.led); end
      end
      if (c == 159) begin
        checks++;
        if (bus.led !== 2'b00) begin failures++; $display("FAIL toggle_off got=%b want=00", bus.led); end
      end
      @(negedge sys_clk);
    end
    checks++;
    if (pulse_q.size() != 2) begin failures++; $display("FAIL toggle_pulses got=%0d want=2", pulse_q.size()); end
    else begin
      checks += 2;
      if (pulse_q[0] != 16) begin failures++; $display("FAIL toggle_lat1 got=%0d want=16", pulse_q[0]); end
      if (pulse_q[1] != 96) begin failures++; $display("FAIL toggle_lat2 got=%0d want=96", pulse_q[1]); end
    end
  endtask

  task automatic test_momentary();
    exp_t e;
    int   rise_c = -1;
    int   fall_c = -1;
    logic b;
    bus.mode = 2'b00;
    for (int c = 0; c < 100; c++) begin
      if (c < 4) b = 1'b1;
      else if (c < 34) b = (((c - 4) / 3) % 2) != 0;
      else if (c < 74) b = 1'b0;
      else b = 1'b1;
      bus.key = {b, 1'b1};
      @(posedge sys_clk); #1;
      if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL mom_sb no expected entry"); end
      else begin
        e = exp_q.pop_front(); checks += 2;
        if (bus.led !== e.led) begin failures++; $display("FAIL mom_led c=%0d got=%b want=%b", c, bus.led, e.led); end
        if (bus.key_press !== e.kp) begin failures++; $display("FAIL mom_press c=%0d got=%b want=%b", c, bus.key_press, e.kp); end
      end
      if (rise_c < 0 && bus.led[1] === 1'b1) rise_c = c;
      if (rise_c >= 0 && fall_c < 0 && bus.led[1] === 1'b0) fall_c = c;
      @(negedge sys_clk);
    end
    checks += 2;
    if (rise_c != 46) begin failures++; $display("FAIL mom_rise got=%0d want=46", rise_c); end
    if (fall_c != 86) begin failures++; $display("FAIL mom_fall got=%0d want=86", fall_c); end
  endtask

  task automatic test_blink();
    exp_t e;
    logic prev = 1'b0;
    bit   have_last = 1'b0;
    int   last_t = 0;
    int   ntrans = 0;
    bus.mode = 2'b10;
    for (int c = 0; c < 120; c++) begin
      bus.key = ((c >= 4 && c < 24) || (c >= 80 && c < 100)) ? 2'b01 : 2'b11;
      @(posedge sys_clk); #1;
      if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL blink_sb no expected entry"); end
      else begin
        e = exp_q.pop_front(); checks += 2;
        if (bus.led !== e.led) begin failures++; $display("FAIL blink_led c=%0d got=%b want=%b", c, bus.led, e.led); end
        if (bus.key_press !== e.kp) begin failures++; $display("FAIL blink_press c=%0d got=%b want=%b", c, bus.key_press, e.kp); end
      end
      if (c > 16 && c < 92 && bus.led[1] !== prev) begin
        if (have_last) begin
          checks++;
          if (c - last_t != 8) begin failures++; $display("FAIL blink_half c=%0d got=%0d want=8", c, c - last_t); end
        end
        have_last = 1'b1;
        last_t    = c;
        ntrans++;
      end
      prev = bus.led[1];
      @(negedge sys_clk);
    end
    checks += 2;
    if (ntrans < 8) begin failures++; $display("FAIL blink_count got=%0d want>=8", ntrans); end
    if (bus.led !== 2'b00) begin failures++; $display("FAIL blink_off got=%b want=00", bus.led); end
  endtask

  task automatic test_radio();
    exp_t e;
    bus.mode = 2'b11;
    for (int c = 0; c < 140; c++) begin
      if (c >= 4 && c < 24) bus.key = 2'b00;
      else if ((c >= 50 && c < 70) || (c >= 100 && c < 120)) bus.key = 2'b01;
      else bus.key = 2'b11;
      @(posedge sys_clk); #1;
      if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL radio_sb no expected entry"); end
      else begin
        e = exp_q.pop_front(); checks += 2;
        if (bus.led !== e.led) begin failures++; $display("FAIL radio_led c=%0d got=%b want=%b", c, bus.led, e.led); end
        if (bus.key_press !== e.kp) begin failures++; $display("FAIL radio_press c=%0d got=%b want=%b", c, bus.key_press, e.kp); end
      end
      if (c == 40) begin
        checks++;
        if (bus.led !== 2'b01) begin failures++; $display("FAIL radio_simul got=%b want=01", bus.led); end
      end
      if (c == 90 || c == 139) begin
        checks++;
        if (bus.led !== 2'b10) begin failures++; $display("FAIL radio_sel c=%0d got=%b want=10", c, bus.led); end
      end
      @(negedge sys_clk);
    end
  endtask

  task automatic test_mode_change();
    exp_t e;
    for (int c = 0; c < 100; c++) begin
      bus.mode = (c >= 62) ? 2'b11 : 2'b01;
      if (c >= 4 && c < 24) bus.key = 2'b00;
      else if (c >= 50 && c < 70) bus.key = 2'b10;
      else bus.key = 2'b11;
      @(posedge sys_clk); #1;
      if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL mchg_sb no expected entry"); end
      else begin
        e = exp_q.pop_front(); checks += 2;
        if (bus.led !== e.led) begin failures++; $display("FAIL mchg_led c=%0d got=%b want=%b", c, bus.led, e.led); end
        if (bus.key_press !== e.kp) begin failures++; $display("FAIL mchg_press c=%0d got=%b want=%b", c, bus.key_press, e.kp); end
      end
      if (c == 40) begin
        checks++;
        if (bus.led !== 2'b11) begin failures++; $display("FAIL mchg_both got=%b want=11", bus.led); end
      end
      if (c == 62) begin
        checks += 2;
        if (bus.led !== 2'b00) begin failures++; $display("FAIL mchg_clear got=%b want=00", bus.led); end
        if (bus.key_press !== 2'b01) begin failures++; $display("FAIL mchg_pulse got=%b want=01", bus.key_press); end
      end
      if (c == 99) begin
        checks++;
        if (bus.led !== 2'b00) begin failures++; $display("FAIL mchg_lost got=%b want=00", bus.led); end
      end
      @(negedge sys_clk);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   npulse = 0;
    int   pulse_c = -1;
    bus.mode = 2'b01;
    for (int c = 0; c < 46; c++) begin
      bus.key = {(c < 40), !(c >= 4 && c < 24)};
      @(posedge sys_clk); #1;
      if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL rmid_sb no expected entry"); end
      else begin
        e = exp_q.pop_front(); checks += 2;
        if (bus.led !== e.led) begin failures++; $display("FAIL rmid_led c=%0d got=%b want=%b", c, bus.led, e.led); end
        if (bus.key_press !== e.kp) begin failures++; $display("FAIL rmid_press c=%0d got=%b want=%b", c, bus.key_press, e.kp); end
      end
      @(negedge sys_clk);
    end
    checks++;
    if (bus.led !== 2'b01) begin failures++; $display("FAIL rmid_pre got=%b want=01", bus.led); end
    #2 rst = 1'b0;
    #1;
    checks += 2;
    if (bus.led !== 2'b00) begin failures++; $display("FAIL rmid_async_led got=%b want=00", bus.led); end
    if (bus.key_press !== 2'b00) begin failures++; $display("FAIL rmid_async_press got=%b want=00", bus.key_press); end
    @(negedge sys_clk);
    for (int c = 0; c < 5; c++) begin
      @(posedge sys_clk); #1;
      checks += 2;
      if (bus.led !== 2'b00) begin failures++; $display("FAIL rmid_hold_led c=%0d got=%b want=00", c, bus.led); end
      if (bus.key_press !== 2'b00) begin failures++; $display("FAIL rmid_hold_press c=%0d got=%b want=00", c, bus.key_press); end
      @(negedge sys_clk);
    end
    rst = 1'b1;
    for (int c = 0; c < 30; c++) begin
      bus.key = 2'b01;
      @(posedge sys_clk); #1;
      if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL rmid_sb2 no expected entry"); end
      else begin
        e = exp_q.pop_front(); checks += 2;
        if (bus.led !== e.led) begin failures++; $display("FAIL rmid_led2 c=%0d got=%b want=%b", c, bus.led, e.led); end
        if (bus.key_press !== e.kp) begin failures++; $display("FAIL rmid_press2 c=%0d got=%b want=%b", c, bus.key_press, e.kp); end
      end
      if (bus.key_press[1] === 1'b1) begin
        npulse++;
        if (pulse_c < 0) pulse_c = c;
      end
      @(negedge sys_clk);
    end
    checks += 3;
    if (npulse != 1) begin failures++; $display("FAIL rmid_npulse got=%0d want=1", npulse); end
    if (pulse_c != 12) begin failures++; $display("FAIL rmid_lat got=%0d want=12", pulse_c); end
    if (bus.led !== 2'b10) begin failures++; $display("FAIL rmid_led_end got=%b want=10", bus.led); end
  endtask

  initial begin
    bus.key  = 2'b11;
    bus.mode = 2'b00;
    rst      = 1'b0;
    repeat (20) @(negedge sys_clk);
    test_reset();
    test_glitch();
    test_toggle();
    test_momentary();
    test_blink();
    test_radio();
    test_mode_change();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
